// File: rtl/axis_spi_pkg.sv
// axis_spi_pkg: shared FSM state encoding and SPI word width for the sequencer
package axis_spi_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;
    localparam int SPI_WORD_WIDTH = 16;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port, one registered read-first read port
module sdp_ram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    // Only the read register is reset; the table survives reset.
    always_ff @(posedge clk) begin
        if (rst) rd <= '0;
        else if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/axis_spi_sequencer.sv
// axis_spi_sequencer: replays words from a config table over AXI4-Stream
// with a programmable idle gap after each accepted word.
module axis_spi_sequencer
    import axis_spi_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = SPI_WORD_WIDTH,
    parameter int ADDR_WIDTH       = 6,
    parameter int GAP_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0]       cfg_wr_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_wr_data,
    input  logic                        start,
    input  logic [ADDR_WIDTH:0]         length,
    input  logic [GAP_WIDTH-1:0]        gap,
    output logic                        busy,
    output logic                        done,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);
    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   idx, len_r;
    logic [GAP_WIDTH-1:0]  gap_r, gap_cnt;
    logic                  launch, hs, last, rd_en;

    assign launch = state == IDLE && start && length != '0;
    assign hs     = state == SEND && m_axis_tready;
    // idx is one bit wider than the address so a full-table length compares exactly
    assign last   = idx + (ADDR_WIDTH+1)'(1) == len_r;

    sdp_ram #(.DW(AXIS_TDATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
        .clk(aclk),
        .rst(areset),
        .we(cfg_wr_en),
        .wa(cfg_wr_addr),
        .wd(cfg_wr_data),
        .re(rd_en),
        .ra(idx[ADDR_WIDTH-1:0]),
        .rd(m_axis_tdata)
    );

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = launch ? FETCH : IDLE;
            FETCH: state_nx = SEND;
            SEND:  state_nx = !m_axis_tready ? SEND : last ? IDLE : gap_r != '0 ? GAP : FETCH;
            GAP:   state_nx = gap_cnt == GAP_WIDTH'(1) ? FETCH : GAP;
        endcase
    end

    always_comb begin
        busy          = state != IDLE;
        m_axis_tvalid = state == SEND;
        rd_en         = state == FETCH;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            idx     <= '0;
            len_r   <= '0;
            gap_r   <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == IDLE && start && length == '0) || (hs && last);
            if (launch) begin
                len_r <= length;
                gap_r <= gap;
                idx   <= '0;
            end
            if (hs) begin
                idx     <= idx + (ADDR_WIDTH+1)'(1);
                gap_cnt <= gap_r;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_axis_spi_sequencer.sv
// tb_axis_spi_sequencer: directed and randomized checks of the sequencer against
// a table-and-arithmetic reference model.
module tb_axis_spi_sequencer;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [5:0]  cfg_wr_addr = '0;
    logic [15:0] cfg_wr_data = '0;
    logic        start = 1'b0;
    logic [6:0]  length = '0;
    logic [15:0] gap = '0;
    logic        busy, done, tvalid;
    logic [15:0] tdata;
    logic        tready = 1'b1;

    logic        s_wr_en = 1'b0;
    logic [1:0]  s_wr_addr = '0;
    logic [15:0] s_wr_data = '0;
    logic        s_start = 1'b0;
    logic [2:0]  s_length = '0;
    logic [15:0] s_gap = '0;
    logic        s_busy, s_done, s_tvalid;
    logic [15:0] s_tdata;
    logic        s_tready = 1'b1;

    axis_spi_sequencer dut (
        .aclk(clk), .areset(areset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .start(start), .length(length), .gap(gap),
        .busy(busy), .done(done),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );

    axis_spi_sequencer #(.ADDR_WIDTH(2)) dut_small (
        .aclk(clk), .areset(areset),
        .cfg_wr_en(s_wr_en), .cfg_wr_addr(s_wr_addr), .cfg_wr_data(s_wr_data),
        .start(s_start), .length(s_length), .gap(s_gap),
        .busy(s_busy), .done(s_done),
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] tbl [64];
    logic [15:0] hs_data[$];
    int          hs_cyc[$];
    int          done_cnt, done_cyc, stab_err, start_cyc;
    bit          busy_seen, tv_seen;
    logic        p_v = 1'b0, p_r = 1'b0, p_rst = 1'b1;
    logic [15:0] p_d = '0;
    int          rdy_mode = 0;
    int          passed = 0, failed = 0, total = 0;

    // Bus monitor: records accepted words, done pulses and stalled-word stability.
    always @(negedge clk) begin
        if (tvalid && tready) begin
            hs_data.push_back(tdata);
            hs_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        if (tvalid) tv_seen = 1;
        if (p_v && !p_r && !p_rst && (!tvalid || tdata != p_d)) stab_err++;
        p_v = tvalid;
        p_r = tready;
        p_d = tdata;
        p_rst = areset;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) tready = 1'b1;
        else if (rdy_mode == 1) tready = $urandom_range(0, 3) != 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 6'(a);
        cfg_wr_data = d;
        tbl[a] = d;
        tick;
        cfg_wr_en = 1'b0;
    endtask

    task automatic start_seq(input int len, input int g);
        hs_data.delete();
        hs_cyc.delete();
        done_cnt = 0;
        busy_seen = 0;
        tv_seen = 0;
        stab_err = 0;
        start = 1'b1;
        length = 7'(len);
        gap = 16'(g);
        start_cyc = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick;
            n++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
        repeat (3) tick;
    endtask

    task automatic wait_hs(input int k);
        int n = 0;
        while (hs_data.size() < k && n < 100) begin
            tick;
            n++;
        end
    endtask

    // Expected: words tbl[0..len-1] in order, handshakes at least gap+2 apart
    // (exactly, with tready held high), done one cycle after the last handshake.
    task automatic verify(input int len, input int g, input bit exact);
        int errs = 0, sp = 0, d;
        chk("word_count", 32'(hs_data.size()), 32'(len));
        for (int i = 0; i < hs_data.size() && i < len; i++)
            if (hs_data[i] !== tbl[i]) errs++;
        chk("word_data", 32'(errs), 0);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            d = hs_cyc[i] - hs_cyc[i-1];
            if (exact ? d != g + 2 : d < g + 2) sp++;
        end
        chk("spacing", 32'(sp), 0);
        if (exact) chk("first_latency", 32'(hs_cyc.size() > 0 ? hs_cyc[0] - start_cyc : -1), 2);
        chk("done_after_last", 32'(hs_cyc.size() > 0 ? done_cyc - hs_cyc[hs_cyc.size()-1] : -1), 1);
        chk("done_once", 32'(done_cnt), 1);
        chk("busy_after", 32'(busy), 0);
        chk("stall_stable", 32'(stab_err), 0);
    endtask

    task automatic run(input int len, input int g, input int mode);
        rdy_mode = mode;
        tick;
        start_seq(len, g);
        wait_done;
        verify(len, g, mode == 0);
    endtask

    initial begin
        int span, cnt, derr, sd;
        logic [15:0] stbl [4];
        repeat (3) tick;
        areset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tdata", 32'(tdata), 0);
        tick;

        wr(0, 16'h1234);
        wr(1, 16'hABCD);
        wr(2, 16'h00FF);
        run(3, 0, 0);

        // word 1 held off by tready low for five cycles
        rdy_mode = 2;
        tready = 1'b1;
        tick;
        start_seq(3, 0);
        wait_hs(1);
        tready = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("stall_tvalid", 32'(tvalid), 1);
        chk("stall_tdata", 32'(tdata), 32'h0000ABCD);
        tick;
        tick;
        tready = 1'b1;
        wait_done;
        verify(3, 0, 0);
        span = hs_cyc.size() > 1 ? hs_cyc[1] - hs_cyc[0] : -1;
        chk("stall_span", 32'(span), 6);

        run(2, 10, 0);

        rdy_mode = 0;
        tick;
        start_seq(0, 0);
        repeat (4) tick;
        chk("len0_done", 32'(done_cnt), 1);
        chk("len0_done_cyc", 32'(done_cyc - start_cyc), 1);
        chk("len0_busy", 32'(busy_seen), 0);
        chk("len0_tvalid", 32'(tv_seen), 0);

        start_seq(3, 3);
        repeat (2) tick;
        start = 1'b1;
        length = 7'd5;
        tick;
        start = 1'b0;
        wait_done;
        verify(3, 3, 1);

        // reset while word 1 is in SEND
        rdy_mode = 2;
        tready = 1'b1;
        tick;
        start_seq(3, 0);
        wait_hs(1);
        tready = 1'b0;
        tick;
        areset = 1'b1;
        tick;
        areset = 1'b0;
        @(negedge clk);
        chk("arst_tvalid", 32'(tvalid), 0);
        chk("arst_busy", 32'(busy), 0);
        repeat (5) tick;
        chk("arst_no_done", 32'(done_cnt), 0);
        run(1, 0, 0);
        chk("arst_table", 32'(hs_data.size() > 0 ? hs_data[0] : 16'h0), 32'h00001234);

        for (int it = 0; it < 6; it++) begin
            repeat (4) wr(int'($urandom_range(0, 63)), 16'($urandom));
            run(int'($urandom_range(1, 12)), int'($urandom_range(0, 4)), int'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 64; i++) wr(i, 16'($urandom));
        run(64, 0, 1);

        for (int i = 0; i < 4; i++) begin
            stbl[i] = 16'($urandom);
            s_wr_en = 1'b1;
            s_wr_addr = 2'(i);
            s_wr_data = stbl[i];
            tick;
        end
        s_wr_en = 1'b0;
        s_start = 1'b1;
        s_length = 3'd4;
        tick;
        s_start = 1'b0;
        cnt = 0;
        derr = 0;
        sd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_tvalid && s_tready) begin
                if (cnt >= 4 || s_tdata !== stbl[cnt]) derr++;
                cnt++;
            end
            if (s_done) sd++;
        end
        chk("small_count", 32'(cnt), 4);
        chk("small_data", 32'(derr), 0);
        chk("small_done", 32'(sd), 1);
        chk("small_busy", 32'(s_busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axis_spi_sequencer.md
AXIS_SPI_SEQUENCER -- requirements
Module: axis_spi_sequencer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 16: width of the config table words and of m_axis_tdata.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: depth of the table is 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter GAP_WIDTH, default 16: width of the inter-word gap count.
REQ-004 SHALL have port aclk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port areset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cfg_wr_en, input, 1: table write strobe.
REQ-007 SHALL have port cfg_wr_addr, input, ADDR_WIDTH: table write address.
REQ-008 SHALL have port cfg_wr_data, input, AXIS_TDATA_WIDTH: table write data.
REQ-009 SHALL have port start, input, 1: single-cycle pulse that launches a sequence.
REQ-010 SHALL have port length, input, ADDR_WIDTH+1: number of words to send, sampled on start.
REQ-011 SHALL have port gap, input, GAP_WIDTH: idle cycles after each accepted word, sampled on start.
REQ-012 SHALL have port busy, output, 1: high from the cycle after an accepted start until the sequence completes.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at sequence completion.
REQ-014 SHALL have port m_axis_tdata, output, AXIS_TDATA_WIDTH: the word for the downstream SPI serializer.
REQ-015 SHALL have ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1): AXI4-Stream handshake.

Function
REQ-016 SHALL implement states IDLE, FETCH, SEND and GAP.
REQ-017 In IDLE, start with length>0 SHALL register length and gap, clear the word index, and go to FETCH; busy rises the next cycle.
REQ-018 In IDLE, start with length=0 SHALL pulse done the next cycle and never assert busy.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 FETCH SHALL take one cycle for the registered table read of the current index, then go to SEND with m_axis_tvalid=1.
REQ-021 In SEND, m_axis_tdata and m_axis_tvalid SHALL stay stable until a cycle with m_axis_tready=1.
REQ-022 After that handshake, the index SHALL increment and m_axis_tvalid SHALL drop the next cycle.
REQ-023 After a handshake, the block SHALL go to GAP when gap>0, otherwise straight to FETCH (or finish).
REQ-024 GAP SHALL last exactly gap cycles, counted by a down-counter, and then go to FETCH.
REQ-025 When the handshake was on the last word (index = length-1), the block SHALL go to IDLE and pulse done, skipping GAP; busy falls in the same cycle done is high.
REQ-026 Minimum spacing with gap=0 and tready held high SHALL be 2 cycles per word (FETCH + SEND).
REQ-027 Table writes SHALL be accepted in any state; a write to the address being fetched in the same cycle SHALL return the old data (read-first).
REQ-028 length=2^ADDR_WIDTH SHALL send the whole table once, with no index wrap-around.
REQ-029 The index SHALL be ADDR_WIDTH+1 bits wide and compare against length without truncation.

Reset
REQ-030 areset SHALL force IDLE, busy=0, done=0, m_axis_tvalid=0, m_axis_tdata=0, index=0 and gap counter=0 on the next edge.
REQ-031 areset mid-sequence SHALL drop m_axis_tvalid at the next edge, even without a handshake, and SHALL NOT produce a done pulse.
REQ-032 Table contents SHALL NOT be cleared by reset.

Structure
REQ-033 The state encodings (IDLE=0, FETCH=1, SEND=2, GAP=3) SHALL live in a shared package, axis_spi_pkg, next to the SPI word-width constant.
REQ-034 The table SHALL be a separate sub-module, sdp_ram: simple dual-port, one write port, one registered read-first read port, inferring block or distributed RAM.
REQ-035 The FSM, counters and handshake logic SHALL stay in axis_spi_sequencer, which targets 150-250 lines.

Verification
REQ-036 Write 0x1234, 0xABCD, 0x00FF to addresses 0-2; start with length=3, gap=0, tready=1 -> words 0x1234, 0xABCD, 0x00FF on cycles N, N+2, N+4; done one cycle after the last handshake.
REQ-037 Same table with tready low for 5 cycles on word 1 -> tdata holds 0xABCD with tvalid high throughout the stall; no word is lost or repeated.
REQ-038 length=2, gap=10 -> exactly 10 idle cycles between the two handshakes, and no gap after the last word.
REQ-039 length=0 -> done pulses once, busy stays 0, tvalid never rises; a start while busy -> ignored, word count unchanged.
REQ-040 areset asserted while word 1 is in SEND -> tvalid=0 and busy=0 the next cycle, no done pulse; table contents intact for a following length=1 sequence (0x1234).
REQ-041 ADDR_WIDTH=2, length=4 -> all four table words sent exactly once, index reaches 4 without wrapping, done pulses.
